pe_dispatcher: RTL and testbench

//  Issuing side of the PE control protocol. Accepts one job command, pulses pe_start,

---
 rtl/pe_proto_pkg.sv | 15 +
 rtl/beat_counter.sv | 24 ++
 rtl/pe_dispatcher.sv | 167 ++++++++++++++++
 tb/tb_pe_dispatcher.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_proto_pkg.sv
// pe_proto_pkg: shared PE control protocol encodings for the dispatcher
package pe_proto_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_FILT, S_IFM, S_CMP, S_WAITD, S_ACC, S_PSUM, S_DRAIN, S_FIN
    } state_t;
    typedef enum logic [1:0] {MODE_0, MODE_1, MODE_2} pe_mode_t;
    localparam logic PE_FUNC_COMPUTE = 1'b0;
    localparam logic PE_FUNC_ACC     = 1'b1;
    localparam logic [1:0] WSEL_FILT = 2'd0;
    localparam logic [1:0] WSEL_IFM  = 2'd1;
    localparam logic [1:0] WSEL_PSUM = 2'd2;
    function automatic logic is_stream(state_t s);
        return s == S_FILT || s == S_IFM || s == S_PSUM;
    endfunction
endpackage

// File: rtl/beat_counter.sv
// beat_counter: saturating beat counter with clear and terminal-count compare
module beat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] n,
    output logic             last
);
    localparam logic [CNT_W-1:0] ONE = 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // clear wins over count; the counter never wraps
    always_comb begin
        cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + ONE : cnt_q;
        last  = (cnt_q == n - ONE) || (cnt_q == '1);
    end
    // count register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pe_dispatcher.sv
// pe_dispatcher: issues one PE job (start, filter/ifmap stream, compute, optional accumulate and drain); optional PERF_CNT_EN adds perf counters
module pe_dispatcher
    import pe_proto_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic              cmd_acc,
    input  logic [CNT_W-1:0]  cmd_filt_n,
    input  logic [CNT_W-1:0]  cmd_ifm_n,
    input  logic [CNT_W-1:0]  cmd_psum_n,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              pe_start,
    output logic [1:0]        pe_mode,
    output logic              pe_change_mode,
    output logic              pe_func,
    output logic              pe_wen,
    output logic [1:0]        pe_wsel,
    output logic [DATA_W-1:0] pe_wdata,
    input  logic              pe_full,
    input  logic              pe_done,
    input  logic              pe_out_valid,
    input  logic [DATA_W-1:0] pe_out_data,
    output logic              pe_out_ren,
    output logic              psum_out_valid,
    output logic [DATA_W-1:0] psum_out_data,
    input  logic              psum_out_ready,
    output logic              busy,
    output logic              job_done
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]       perf_busy,
    output logic [31:0]       perf_stall
`endif
);
    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] filt_n_q, filt_n_d, ifm_n_q, ifm_n_d, psum_n_q, psum_n_d;
    logic             cmd_ready_q, cmd_ready_d, pe_start_q, pe_start_d;
    logic             pe_cm_q, pe_cm_d, pe_func_q, pe_func_d;
    logic             busy_q, busy_d, job_done_q, job_done_d;
    logic             stream, xfer, pop, last;
    logic [CNT_W-1:0] cnt_n;
    // streaming and drain handshakes are combinational and suppressed during reset
    always_comb begin
        stream         = is_stream(state_q);
        src_ready      = stream && !pe_full && !rst;
        xfer           = src_valid && src_ready;
        pe_wen         = xfer;
        pe_wsel        = state_q == S_IFM ? WSEL_IFM : state_q == S_PSUM ? WSEL_PSUM : WSEL_FILT;
        pe_wdata       = stream ? src_data : '0;
        pop            = state_q == S_DRAIN && pe_out_valid && psum_out_ready && !rst;
        pe_out_ren     = pop;
        psum_out_valid = state_q == S_DRAIN && pe_out_valid;
        psum_out_data  = state_q == S_DRAIN ? pe_out_data : '0;
        cnt_n          = state_q == S_FILT ? filt_n_q : state_q == S_IFM ? ifm_n_q : psum_n_q;
    end
    // next-state, command latch and registered strobe decode
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        filt_n_d = filt_n_q;
        ifm_n_d  = ifm_n_q;
        psum_n_d = psum_n_q;
        case (state_q)
            S_IDLE: if (cmd_valid && cmd_ready_q) begin
                state_d  = S_START;
                mode_d   = cmd_mode;
                acc_d    = cmd_acc;
                filt_n_d = cmd_filt_n;
                ifm_n_d  = cmd_ifm_n;
                psum_n_d = cmd_psum_n;
            end
            S_START: state_d = filt_n_q != '0 ? S_FILT : ifm_n_q != '0 ? S_IFM : S_CMP;
            S_FILT:  if (xfer && last) state_d = ifm_n_q != '0 ? S_IFM : S_CMP;
            S_IFM:   if (xfer && last) state_d = S_CMP;
            S_CMP:   state_d = S_WAITD;
            S_WAITD: if (pe_done) state_d = acc_q ? S_ACC : S_FIN;
            S_ACC:   state_d = psum_n_q != '0 ? S_PSUM : S_FIN;
            S_PSUM:  if (xfer && last) state_d = S_DRAIN;
            S_DRAIN: if (pop && last) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = state_d == S_IDLE;
        pe_start_d  = state_d == S_START;
        pe_cm_d     = state_d == S_CMP || state_d == S_ACC;
        pe_func_d   = state_d == S_ACC ? PE_FUNC_ACC : PE_FUNC_COMPUTE;
        busy_d      = state_d != S_IDLE;
        job_done_d  = state_d == S_FIN;
    end
    beat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_d != state_q),
        .en   (xfer || pop),
        .n    (cnt_n),
        .last (last)
    );
    // FSM state, latched command and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_0;
            acc_q       <= 1'b0;
            filt_n_q    <= '0;
            ifm_n_q     <= '0;
            psum_n_q    <= '0;
            cmd_ready_q <= 1'b1;
            pe_start_q  <= 1'b0;
            pe_cm_q     <= 1'b0;
            pe_func_q   <= 1'b0;
            busy_q      <= 1'b0;
            job_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            filt_n_q    <= filt_n_d;
            ifm_n_q     <= ifm_n_d;
            psum_n_q    <= psum_n_d;
            cmd_ready_q <= cmd_ready_d;
            pe_start_q  <= pe_start_d;
            pe_cm_q     <= pe_cm_d;
            pe_func_q   <= pe_func_d;
            busy_q      <= busy_d;
            job_done_q  <= job_done_d;
        end
    end
    assign cmd_ready      = cmd_ready_q;
    assign pe_start       = pe_start_q;
    assign pe_mode        = mode_q;
    assign pe_change_mode = pe_cm_q;
    assign pe_func        = pe_func_q;
    assign busy           = busy_q;
    assign job_done       = job_done_q;
`ifdef PERF_CNT_EN
    logic [31:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d;
    // saturating activity and stall counters, cleared only by reset
    always_comb begin
        perf_busy_d  = (busy_q && perf_busy_q != '1) ? perf_busy_q + 32'd1 : perf_busy_q;
        perf_stall_d = (((src_valid && pe_full) || state_q == S_WAITD) && perf_stall_q != '1)
                     ? perf_stall_q + 32'd1 : perf_stall_q;
    end
    // perf counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end
    assign perf_busy  = perf_busy_q;
    assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_pe_dispatcher.sv
// tb_pe_dispatcher: directed self-checking bench for pe_dispatcher
module tb_pe_dispatcher;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0, cmd_ready, cmd_acc = 1'b0;
    logic [1:0]        cmd_mode = 2'd0;
    logic [CNT_W-1:0]  cmd_filt_n = '0, cmd_ifm_n = '0, cmd_psum_n = '0;
    logic              src_valid = 1'b0, src_ready;
    logic [DATA_W-1:0] src_data = 16'h0100;
    logic              pe_start, pe_change_mode, pe_func, pe_wen;
    logic [1:0]        pe_mode, pe_wsel;
    logic [DATA_W-1:0] pe_wdata;
    logic              pe_full = 1'b0, pe_done = 1'b0, pe_out_valid = 1'b0;
    logic [DATA_W-1:0] pe_out_data = '0;
    logic              pe_out_ren, psum_out_valid, psum_out_ready = 1'b0;
    logic [DATA_W-1:0] psum_out_data;
    logic              busy, job_done;

    int vectors = 0;
    int miscompares = 0;
    int n_start = 0, n_cmp = 0, n_acc = 0, n_pop = 0, n_done = 0, n_bad = 0, n_w = 0;
    int n_wen[4] = '{0, 0, 0, 0};
    logic [DATA_W-1:0] wdat[256];
    logic [1:0]        wsl[256];

    pe_dispatcher #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_acc(cmd_acc), .cmd_filt_n(cmd_filt_n),
        .cmd_ifm_n(cmd_ifm_n), .cmd_psum_n(cmd_psum_n), .src_valid(src_valid),
        .src_data(src_data), .src_ready(src_ready), .pe_start(pe_start),
        .pe_mode(pe_mode), .pe_change_mode(pe_change_mode), .pe_func(pe_func),
        .pe_wen(pe_wen), .pe_wsel(pe_wsel), .pe_wdata(pe_wdata), .pe_full(pe_full),
        .pe_done(pe_done), .pe_out_valid(pe_out_valid), .pe_out_data(pe_out_data),
        .pe_out_ren(pe_out_ren), .psum_out_valid(psum_out_valid),
        .psum_out_data(psum_out_data), .psum_out_ready(psum_out_ready),
        .busy(busy), .job_done(job_done)
    );

    always #5 clk = ~clk;

    // event monitor sampled on the falling edge
    always @(negedge clk) begin
        if (pe_start) n_start++;
        if (pe_change_mode && !pe_func) n_cmp++;
        if (pe_change_mode && pe_func) n_acc++;
        if (pe_out_ren) n_pop++;
        if (job_done) n_done++;
        if (pe_wen && pe_full) n_bad++;
        if (pe_wen) begin
            n_wen[pe_wsel]++;
            wdat[n_w % 256] = pe_wdata;
            wsl[n_w % 256]  = pe_wsel;
            n_w++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic x;
        @(negedge clk);
        x = src_valid && src_ready;
        @(posedge clk);
        #1;
        if (x) src_data = src_data + 16'd1;
    endtask

    task automatic issue(input logic [1:0] m, input logic a, input int f, input int i, input int p);
        cmd_mode = m; cmd_acc = a;
        cmd_filt_n = CNT_W'(f); cmd_ifm_n = CNT_W'(i); cmd_psum_n = CNT_W'(p);
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cmp(input string tag);
        int k = 0;
        while (!pe_change_mode && k < 60) begin
            cyc();
            k++;
        end
        check(tag, {31'd0, pe_change_mode}, 32'd1);
    endtask

    task automatic finish_job(input string tag);
        pe_done = 1'b1;
        cyc();
        pe_done = 1'b0;
        check({tag, "_job_done"}, {31'd0, job_done}, 32'd1);
        cyc();
        check({tag, "_job_done_pulse"}, {31'd0, job_done}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic check_order(input string tag, input int base, input int cnt,
                               input logic [DATA_W-1:0] d0, input logic [1:0] ws);
        logic ok = 1'b1;
        for (int i = 0; i < cnt; i++)
            if (wdat[(base + i) % 256] !== d0 + DATA_W'(i) || wsl[(base + i) % 256] !== ws) ok = 1'b0;
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int bs, bw, b0, b1, b2, bc, ba, bp, bd;
        logic [DATA_W-1:0] d0;
        logic ok;
        repeat (3) cyc();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pe_start", {31'd0, pe_start}, 32'd0);
        check("rst_pe_mode", {30'd0, pe_mode}, 32'd0);
        check("rst_job_done", {31'd0, job_done}, 32'd0);
        rst = 1'b0;
        cyc();

        // T1: reset in the middle of FILT
        src_valid = 1'b1;
        issue(2'd2, 1'b0, 10, 0, 0);
        cyc();
        cyc();
        check("t1_wen_in_filt", {31'd0, pe_wen}, 32'd1);
        bw = n_w; bs = n_start;
        rst = 1'b1;
        #1;
        check("t1_wen_gated", {31'd0, pe_wen}, 32'd0);
        repeat (3) cyc();
        rst = 1'b0;
        check("t1_no_writes", n_w, bw);
        check("t1_no_start", n_start, bs);
        check("t1_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_pe_mode", {30'd0, pe_mode}, 32'd0);
        src_valid = 1'b0;
        cyc();

        // T2: basic job
        bs = n_start; bw = n_w; b0 = n_wen[0]; b1 = n_wen[1]; bc = n_cmp; bd = n_done;
        src_valid = 1'b1;
        d0 = src_data;
        issue(2'd0, 1'b0, 3, 5, 0);
        check("t2_pe_start", {31'd0, pe_start}, 32'd1);
        check("t2_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        wait_cmp("t2_cmp_seen");
        check("t2_func_compute", {31'd0, pe_func}, 32'd0);
        cyc();
        check("t2_waitd_busy", {31'd0, busy}, 32'd1);
        check("t2_cm_one_cycle", {31'd0, pe_change_mode}, 32'd0);
        cyc();
        check("t2_wait_holds", {31'd0, job_done}, 32'd0);
        finish_job("t2");
        check("t2_starts", n_start - bs, 1);
        check("t2_filt_writes", n_wen[0] - b0, 3);
        check("t2_ifm_writes", n_wen[1] - b1, 5);
        check("t2_cmp_strobes", n_cmp - bc, 1);
        check("t2_done_pulses", n_done - bd, 1);
        check_order("t2_filt_order", bw, 3, d0, 2'd0);
        check_order("t2_ifm_order", bw + 3, 5, d0 + 16'd3, 2'd1);

        // T3: backpressure during IFM
        bw = n_w; b0 = n_wen[0]; b1 = n_wen[1];
        d0 = src_data;
        issue(2'd0, 1'b0, 0, 4, 0);
        begin
            int k = 0;
            while (!pe_change_mode && k < 60) begin
                pe_full = ~pe_full;
                cyc();
                k++;
            end
        end
        pe_full = 1'b0;
        check("t3_cmp_seen", {31'd0, pe_change_mode}, 32'd1);
        cyc();
        finish_job("t3");
        check("t3_ifm_writes", n_wen[1] - b1, 4);
        check("t3_filt_writes", n_wen[0] - b0, 0);
        check("t3_no_write_full", n_bad, 0);
        check_order("t3_ifm_order", bw, 4, d0, 2'd1);

        // T4: accumulate job with result backpressure
        bw = n_w; b2 = n_wen[2]; ba = n_acc; bp = n_pop;
        d0 = src_data;
        issue(2'd1, 1'b1, 1, 1, 2);
        wait_cmp("t4_cmp_seen");
        check("t4_cmp_func", {31'd0, pe_func}, 32'd0);
        cyc();
        pe_done = 1'b1;
        cyc();
        pe_done = 1'b0;
        check("t4_acc_strobe", {31'd0, pe_change_mode}, 32'd1);
        check("t4_acc_func", {31'd0, pe_func}, 32'd1);
        check("t4_no_done_yet", {31'd0, job_done}, 32'd0);
        repeat (3) cyc();
        src_valid = 1'b0;
        pe_out_valid = 1'b1;
        pe_out_data = 16'hA5A5;
        #1;
        check("t4_drain_valid", {31'd0, psum_out_valid}, 32'd1);
        ok = 1'b1;
        repeat (3) begin
            cyc();
            if (psum_out_data !== 16'hA5A5 || !psum_out_valid || pe_out_ren) ok = 1'b0;
        end
        check("t4_stall_hold", {31'd0, ok}, 32'd1);
        check("t4_stall_no_pop", n_pop - bp, 0);
        check("t4_psum_writes", n_wen[2] - b2, 2);
        check_order("t4_psum_order", bw + 2, 2, d0 + 16'd2, 2'd2);
        psum_out_ready = 1'b1;
        #1;
        check("t4_ren", {31'd0, pe_out_ren}, 32'd1);
        cyc();
        pe_out_data = 16'h5A5A;
        #1;
        check("t4_data2", {16'd0, psum_out_data}, 32'h5A5A);
        check("t4_not_done_mid", {31'd0, job_done}, 32'd0);
        cyc();
        pe_out_valid = 1'b0;
        psum_out_ready = 1'b0;
        check("t4_job_done", {31'd0, job_done}, 32'd1);
        check("t4_pe_mode", {30'd0, pe_mode}, 32'd1);
        cyc();
        check("t4_pops", n_pop - bp, 2);
        check("t4_acc_strobes", n_acc - ba, 1);
        check("t4_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // T5: zero counts go straight to compute
        bw = n_w;
        src_valid = 1'b1;
        issue(2'd0, 1'b0, 0, 0, 0);
        cyc();
        check("t5_direct_cmp", {31'd0, pe_change_mode}, 32'd1);
        cyc();
        finish_job("t5");
        check("t5_no_writes", n_w - bw, 0);

        // T6: spurious pe_done during FILT is ignored
        src_valid = 1'b0;
        bd = n_done;
        issue(2'd0, 1'b0, 2, 1, 0);
        cyc();
        pe_done = 1'b1;
        cyc();
        pe_done = 1'b0;
        check("t6_still_busy", {31'd0, busy}, 32'd1);
        src_valid = 1'b1;
        wait_cmp("t6_cmp_seen");
        cyc();
        ok = 1'b1;
        repeat (3) begin
            cyc();
            if (job_done || !busy) ok = 1'b0;
        end
        check("t6_waitd_holds", {31'd0, ok}, 32'd1);
        finish_job("t6");
        check("t6_one_done", n_done - bd, 1);
        src_valid = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
